// File: rtl/seq_alu_pkg.sv
// Shared opcode values and FSM state type for the sequential accumulator/ALU.
package seq_alu_pkg;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ROT  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mul.sv
// WIDTH-step shift-add multiplier; product/last present the result of the step
// taken at the coming edge so the owner can capture it on that same edge.
module seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               last
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     sum;

    // Upper half accumulates the multiplicand; lower half shifts out multiplier bits.
    always_comb begin
        sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        product = {sum, prod_q[WIDTH-1:1]};
        last    = (cnt_q == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else if (start) begin
            mcand_q <= a;
            prod_q  <= {{WIDTH{1'b0}}, b};
            cnt_q   <= CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            prod_q  <= product;
            cnt_q   <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu_acc.sv
// WIDTH-bit accumulator with inline single-cycle ALU, multi-cycle multiply and
// rotate, and a valid/ready command port that accepts only while idle.
module seq_alu_acc
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    output logic [WIDTH-1:0] acc,
    output logic             flag_c,
    output logic             flag_z,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic               c_q;
    logic               z_q;
    logic               done_q;
    logic [CNT_W-1:0]   rot_cnt_q;

    logic [WIDTH-1:0]   alu_acc_d;
    logic               alu_c_d;
    logic [WIDTH-1:0]   rot_acc_d;
    logic [CNT_W-1:0]   rot_n;
    logic               mul_start;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_product;

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign acc       = acc_q;
    assign flag_c    = c_q;
    assign flag_z    = z_q;
    assign done      = done_q;

    assign mul_start = cmd_valid && cmd_ready && (cmd_op == OP_MUL);
    assign rot_n     = CNT_W'(cmd_operand % WIDTH);
    assign rot_acc_d = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};

    seq_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .a      (acc_q),
        .b      (cmd_operand),
        .product(mul_product),
        .last   (mul_last)
    );

    // Single-cycle results; ROL with zero count falls through to the default.
    always_comb begin
        alu_acc_d = acc_q;
        alu_c_d   = 1'b0;
        case (cmd_op)
            OP_LOAD: alu_acc_d = cmd_operand;
            OP_ADD:  {alu_c_d, alu_acc_d} = {1'b0, acc_q} + {1'b0, cmd_operand};
            OP_SUB: begin
                alu_acc_d = acc_q - cmd_operand;
                alu_c_d   = (cmd_operand > acc_q);
            end
            OP_SHL: begin
                alu_acc_d = {acc_q[WIDTH-2:0], cmd_operand[0]};
                alu_c_d   = acc_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_acc_d = {cmd_operand[0], acc_q[WIDTH-1:1]};
                alu_c_d   = acc_q[0];
            end
            OP_CLR:  alu_acc_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            c_q       <= 1'b0;
            z_q       <= 1'b1;
            done_q    <= 1'b0;
            rot_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == OP_MUL) begin
                            state_q <= ST_MUL;
                        end else if (cmd_op == OP_ROL && rot_n != '0) begin
                            state_q   <= ST_ROT;
                            rot_cnt_q <= rot_n;
                        end else begin
                            acc_q  <= alu_acc_d;
                            c_q    <= alu_c_d;
                            z_q    <= (alu_acc_d == '0);
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_last) begin
                        acc_q   <= mul_product[WIDTH-1:0];
                        c_q     <= |mul_product[2*WIDTH-1:WIDTH];
                        z_q     <= (mul_product[WIDTH-1:0] == '0);
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_ROT: begin
                    acc_q     <= rot_acc_d;
                    c_q       <= acc_q[WIDTH-1];
                    z_q       <= (rot_acc_d == '0);
                    rot_cnt_q <= rot_cnt_q - 1'b1;
                    if (rot_cnt_q == CNT_W'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_acc.sv
// Directed bench for seq_alu_acc: arithmetic reference model checked every
// cycle, plus hand-computed expectations at key points of the sequence.
module tb_seq_alu_acc;

    localparam int W = 4;
    localparam int M = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_operand;
    logic [W-1:0] acc;
    logic         flag_c;
    logic         flag_z;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    seq_alu_acc #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_operand(cmd_operand),
        .acc        (acc),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural values.
    int m_acc = 0, m_c = 0, m_done = 0, m_busy = 0, m_kind = 0, m_left = 0;
    int m_pacc = 0, m_pc = 0;
    bit started = 0;

    always @(posedge clk) begin
        int opnd, prod, s;
        started = 1;
        opnd = int'(cmd_operand);
        if (rst) begin
            m_acc = 0; m_c = 0; m_done = 0; m_busy = 0; m_left = 0;
        end else if (m_busy == 0) begin
            m_done = 0;
            if (cmd_valid) begin
                case (cmd_op)
                    3'd0: begin m_acc = opnd; m_c = 0; m_done = 1; end
                    3'd1: begin s = m_acc + opnd; m_acc = s % M; m_c = (s >= M); m_done = 1; end
                    3'd2: begin m_c = (opnd > m_acc); m_acc = (m_acc - opnd + M) % M; m_done = 1; end
                    3'd3: begin
                        prod = m_acc * opnd;
                        m_pacc = prod % M; m_pc = (prod >= M);
                        m_busy = 1; m_kind = 0; m_left = W;
                    end
                    3'd4: begin m_c = m_acc / (M / 2); m_acc = (m_acc * 2 + opnd % 2) % M; m_done = 1; end
                    3'd5: begin m_c = m_acc % 2; m_acc = m_acc / 2 + (opnd % 2) * (M / 2); m_done = 1; end
                    3'd6: begin
                        if (opnd % W == 0) begin m_c = 0; m_done = 1; end
                        else begin m_busy = 1; m_kind = 1; m_left = opnd % W; end
                    end
                    default: begin m_acc = 0; m_c = 0; m_done = 1; end
                endcase
            end
        end else begin
            m_done = 0;
            m_left--;
            if (m_kind == 1) begin
                m_c = m_acc / (M / 2);
                m_acc = (m_acc * 2) % M + m_c;
            end
            if (m_left == 0) begin
                if (m_kind == 0) begin m_acc = m_pacc; m_c = m_pc; end
                m_busy = 0;
                m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_acc",   int'(acc),       m_acc);
            chk("model_c",     int'(flag_c),    m_c);
            chk("model_z",     int'(flag_z),    int'(m_acc == 0));
            chk("model_busy",  int'(busy),      m_busy);
            chk("model_ready", int'(cmd_ready), int'(m_busy == 0));
            chk("model_done",  int'(done),      m_done);
        end
    end

    // Drive a command at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic issue(input logic [2:0] op, input int opnd);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_operand = W'(opnd);
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(posedge clk); #1;
        end
        if (n >= 20) chk("busy_timeout", n, 0);
    endtask

    initial begin
        int n, dones;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_operand = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_acc", int'(acc), 0);
        chk("rst_z", int'(flag_z), 1);
        chk("rst_c", int'(flag_c), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);

        issue(3'd0, 9);
        chk("load9_acc", int'(acc), 9);
        chk("load9_z", int'(flag_z), 0);
        chk("load9_done", int'(done), 1);
        issue(3'd1, 9);
        chk("add9_acc", int'(acc), 2);
        chk("add9_c", int'(flag_c), 1);
        chk("add9_done", int'(done), 1);

        issue(3'd2, 3);
        chk("sub3_acc", int'(acc), 15);
        chk("sub3_c", int'(flag_c), 1);
        issue(3'd2, 15);
        chk("sub15_acc", int'(acc), 0);
        chk("sub15_c", int'(flag_c), 0);
        chk("sub15_z", int'(flag_z), 1);

        // MUL 7*3 with a LOAD 1 held valid throughout the busy window
        issue(3'd0, 7);
        issue(3'd3, 3);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_operand = W'(1);
        chk("mul_ready_low", int'(cmd_ready), 0);
        count_busy(n);
        chk("mul_busy_cycles", n, 4);
        chk("mul_acc", int'(acc), 5);
        chk("mul_c", int'(flag_c), 1);
        chk("mul_done", int'(done), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("held_load_acc", int'(acc), 1);

        issue(3'd0, 9);
        issue(3'd6, 1);
        count_busy(n);
        chk("rol1_cycles", n, 1);
        chk("rol1_acc", int'(acc), 3);
        chk("rol1_c", int'(flag_c), 1);
        issue(3'd6, 0);
        chk("rol0_acc", int'(acc), 3);
        chk("rol0_c", int'(flag_c), 0);
        chk("rol0_busy", int'(busy), 0);
        chk("rol0_done", int'(done), 1);
        issue(3'd6, 6);
        count_busy(n);
        chk("rol6_cycles", n, 2);
        chk("rol6_acc", int'(acc), 12);
        chk("rol6_c", int'(flag_c), 0);

        // Abort a multiply with reset on its second busy cycle
        issue(3'd0, 7);
        issue(3'd3, 3);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_acc", int'(acc), 0);
        chk("abort_z", int'(flag_z), 1);
        chk("abort_c", int'(flag_c), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        dones = int'(done);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            dones += int'(done);
        end
        chk("abort_no_done", dones, 0);

        issue(3'd0, 8);
        issue(3'd4, 1);
        chk("shl_acc", int'(acc), 1);
        chk("shl_c", int'(flag_c), 1);
        issue(3'd5, 0);
        chk("shr_acc", int'(acc), 0);
        chk("shr_c", int'(flag_c), 1);
        chk("shr_z", int'(flag_z), 1);
        issue(3'd5, 1);
        chk("shr_fill_acc", int'(acc), 8);
        issue(3'd7, 0);
        chk("clr_acc", int'(acc), 0);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got %0t expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_alu_acc.md
Name: seq_alu_acc

Overview:
- Parametrised successor to the 4-bit register/ALU pair: a WIDTH-bit accumulator with an integrated ALU and a valid/ready command port.
- Single-cycle ops: load, add, sub, shift, clear.
- Multi-cycle ops: shift-add multiply and rotate.
- Sits between a command sequencer and downstream datapath; the accumulator value and flags are always visible.

Parameters:
WIDTH, 4, accumulator/operand width in bits (>=2)
CNT_W, $clog2(WIDTH)+1, internal iteration counter width (derived, not overridden)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  unit can accept command (high only in IDLE)
cmd_op  in  3  opcode
cmd_operand  in  WIDTH  operand B / shift fill / rotate count
acc  out  WIDTH  accumulator (registered)
flag_c  out  1  carry/borrow/overflow of last completed op (registered)
flag_z  out  1  acc==0 (registered, tracks acc)
busy  out  1  multi-cycle op in progress
done  out  1  one-cycle pulse, cycle after any op completes

Behaviour:
- Reset (rst high at edge, any state, including mid-op): acc=0, flag_c=0, flag_z=1, done=0, busy=0, state=IDLE. cmd_ready=1 in the following cycle. An aborted op never pulses done.
- Accept = cmd_valid && cmd_ready at a rising edge. cmd_ready = (state==IDLE), combinational from state only. cmd_valid while busy is ignored; no queueing.
- Opcodes:
  - 000 LOAD: acc=operand, c=0.
  - 001 ADD: {c,acc}=acc+operand.
  - 010 SUB: acc=acc-operand mod 2^WIDTH, c=1 iff operand>acc (borrow).
  - 011 MUL: multi-cycle, see below.
  - 100 SHL: acc={acc[W-2:0],operand[0]}, c=old acc[W-1].
  - 101 SHR: acc={operand[0],acc[W-1:1]}, c=old acc[0].
  - 110 ROL: multi-cycle, see below.
  - 111 CLR: acc=0, c=0.
- Single-cycle ops: acc/flag_c update at the accept edge; done=1 for exactly the next cycle; state stays IDLE, so back-to-back accepts every cycle are legal.
- States: IDLE, MUL, ROT.
- MUL:
  - At the accept edge, latch multiplicand=acc and multiplier=operand into a 2*WIDTH product register; cnt=WIDTH; state->MUL; busy=1.
  - Each cycle performs one shift-add step and decrements cnt.
  - On the step where cnt reaches 0: acc=product[W-1:0], flag_c = (product[2W-1:W]!=0), state->IDLE.
  - Results are written exactly WIDTH edges after accept; done is high the following cycle.
- ROL:
  - Count n = operand mod WIDTH.
  - n==0: behaves as a single-cycle op; acc unchanged, c=0.
  - Otherwise state->ROT, busy=1; one bit rotated left per cycle with c = bit rotated out; the final write is n edges after accept.
- flag_z always equals (acc==0), registered alongside acc.
- busy=1 exactly while state!=IDLE.
- done and cmd_ready can both be high in the same cycle.

Decomposition:
- Package seq_alu_pkg holds:
  - opcode localparams (OP_LOAD..OP_CLR, 3-bit);
  - state encoding (ST_IDLE, ST_MUL, ST_ROT).
- One sub-module is natural: seq_mul, the WIDTH-parametrised shift-add iterator.
  - Inputs: start, a, b.
  - Outputs: product[2W-1:0], last.
  - Synchronous rst.
- Rotate, shifts and add/sub stay inline in seq_alu_acc.

Test Plan:
- rst 1 cycle, then LOAD 9, then ADD 9 (WIDTH=4) -> acc=9, z=0 after first; acc=2, c=1 after second; done pulses once per op on consecutive cycles.
- From acc=2, SUB 3 -> acc=15, c=1. Then SUB 15 -> acc=0, c=0, z=1.
- acc=7, MUL 3 -> cmd_ready low and busy high for 4 cycles; acc=5 (21 mod 16), c=1 written 4 edges after accept. A cmd_valid LOAD 1 held during busy is not accepted until ready returns.
- acc=4'b1001: ROL 1 -> 4'b0011 after 1 edge, c=1. ROL 0 -> unchanged, single-cycle, c=0. ROL 6 (mod 4 = 2) -> 2 cycles busy.
- Start MUL 7*3, assert rst on 2nd busy cycle -> next cycle acc=0, z=1, c=0, busy=0, cmd_ready=1; no done pulse ever appears for the aborted op.
- SHL with operand[0]=1 on acc=4'b1000 -> acc=4'b0001, c=1. SHR with fill 0 on 4'b0001 -> 0, c=1, z=1.
